dlmiles_tqvph_i2c: RTL and testbench
====================================

Name: dlmiles_tqvph_i2c

Overview:
- Tiny Tapeout top-level wrapping a byte-oriented I2C master with a pin-level command interface.
- Commands are strobed in on uio_in[7:4]; command data comes from ui_in.
- SDA and SCL are open-drain on uio[0] and uio[1].
- Received data appears on uo_out; busy and NACK status appear on uio_out[3:2].

Parameters:
- DEFAULT_DIV, 8'd4: reset value of the quarter-bit clock divider.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset; the reset is synchronous and active-high (asserted = 1). The port name follows the codebase harness convention.
- ena  in  1  tile enable; ignored.
- ui_in  in  8  command data byte (write data or divider value).
- uo_out  out  8  last received read byte.
- uio_in  in  8  [0] SDA sense, [1] SCL sense, [3:2] unused, [6:4] opcode, [7] strobe.
- uio_out  out  8  [1:0] always 0 (open-drain low level), [2] busy, [3] nack, [7:4] 0.
- uio_oe  out  8  [0] 1 = pull SDA low, [1] 1 = pull SCL low, [3:2] always 1, [7:4] always 0.

Behaviour:
- Reset values:
  - uo_out = 0, busy = 0, nack = 0, div = DEFAULT_DIV.
  - SDA and SCL released, so uio_oe = 8'h0C and uio_out = 0.
  - Strobe edge register = 0; FSM in IDLE.
- Strobe handling:
  - Strobe is registered once; a 0→1 edge on uio_in[7] is a command request.
  - A request is accepted only in IDLE; requests while busy are dropped.
  - busy goes 1 on the cycle after the edge is detected and returns to 0 on the cycle the sequence finishes.
  - ui_in is latched when the command is accepted.
- Opcodes:
  - 0 NOP: no busy pulse.
  - 1 START.
  - 2 STOP.
  - 3 WRITE ui_in.
  - 4 READ+ACK.
  - 5 READ+NACK.
  - 6 SET_DIV: div ← ui_in, no bus activity, no busy pulse.
  - 7 RESTART: same sequence as START.
- Quarter timing: a quarter lasts div+1 clk cycles (div = 0 gives 1 cycle).
- Clock stretching: in any quarter where SCL is released, the quarter counter holds while uio_in[1] = 0.
- START/RESTART (4 quarters):
  - Q0: release SDA; SCL stays at its prior drive.
  - Q1: release SCL (stretch-wait).
  - Q2: pull SDA low.
  - Q3: pull SCL low.
- STOP (4 quarters):
  - Q0: pull SDA low, SCL low.
  - Q1: release SCL (stretch-wait).
  - Q2: hold.
  - Q3: release SDA.
- Bit cell (4 quarters):
  - Q0: SCL low, SDA set to the bit value (released = 1).
  - Q1: release SCL (stretch-wait).
  - Q2: SCL high; SDA sampled on the last cycle of Q2.
  - Q3: pull SCL low.
- WRITE:
  - 8 bits MSB first, then a 9th bit with SDA released.
  - nack ← sampled SDA of the 9th bit (1 = NACK).
- READ:
  - 8 bits with SDA released, shifted in MSB first.
  - uo_out ← the byte at the end of bit 8.
  - 9th bit: SDA pulled low for opcode 4, released for opcode 5.
  - nack is unchanged.
- SCL/SDA ownership:
  - After START, SCL stays pulled low between commands; after STOP both lines are released.
  - WRITE or READ issued without a prior START is still executed as-is, with no protocol checking.
- Reset mid-operation: all state returns to reset values on the next clk edge and both lines are released immediately.
- nack and uo_out hold their values until the next WRITE or READ respectively.

Test Plan:
1. Assert reset → uio_oe = 8'h0C, uo_out = 0, uio_out[3:2] = 0; then SET_DIV 0 → no busy pulse.
2. div = 1, START → SDA falls while SCL is high, then SCL falls; busy is high for 8 cycles plus 1 edge cycle.
3. WRITE 0xA5, slave pulls SDA low on the 9th bit → bus shows 1010_0101 MSB first, nack = 0; repeat with SDA released → nack = 1.
4. READ+NACK with the slave driving 0x3C → uo_out = 0x3C; 9th-bit SDA is released. READ+ACK → 9th-bit SDA is low.
5. Hold uio_in[1] low for 20 cycles during Q1 of a bit → the quarter is extended by exactly the stretch time; data is unaffected.
6. Strobe while busy → ignored (byte count unchanged); STOP → SDA rises while SCL is high and both lines end released.

Source files
------------

// File: rtl/dlmiles_tqvph_i2c.sv
// Byte-oriented I2C master behind a Tiny Tapeout pin interface: commands are
// strobed on uio_in[7:4], SDA/SCL are open-drain on uio[0]/uio[1].
module dlmiles_tqvph_i2c #(
  parameter logic [7:0] DEFAULT_DIV = 8'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_STOP,
    ST_BIT
  } state_t;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_START     = 3'd1;
  localparam logic [2:0] OP_STOP      = 3'd2;
  localparam logic [2:0] OP_WRITE     = 3'd3;
  localparam logic [2:0] OP_READ_ACK  = 3'd4;
  localparam logic [2:0] OP_READ_NACK = 3'd5;
  localparam logic [2:0] OP_SET_DIV   = 3'd6;
  localparam logic [2:0] OP_RESTART   = 3'd7;

  state_t     state, state_nx;
  logic       strobe_q;
  logic [7:0] div;
  logic [7:0] cnt;
  logic [1:0] quarter;
  logic [3:0] bit_idx;
  logic [7:0] shreg;
  logic       is_read;
  logic       ack_low;
  logic       sda_sample;
  logic       idle_sda;
  logic       idle_scl;
  logic       nack;
  logic [7:0] rx_byte;
  logic       busy;

  logic       sda_pull;
  logic       scl_pull;
  logic       req;
  logic       stretch;
  logic       tick;
  logic       last_q;
  logic       bit_val;
  logic [2:0] op;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[3:2]};

  assign op = uio_in[6:4];

  always_comb begin
    req      = uio_in[7] & ~strobe_q;
    // Bits 0..7 come from the shift register (all ones for a read);
    // the 9th bit is released except for a read that ACKs.
    bit_val  = (bit_idx == 4'd8) ? ~ack_low : shreg[7];
    sda_pull = idle_sda;
    scl_pull = idle_scl;
    unique case (state)
      ST_START: begin
        unique case (quarter)
          2'd0: begin sda_pull = 1'b0; scl_pull = idle_scl; end
          2'd1: begin sda_pull = 1'b0; scl_pull = 1'b0;     end
          2'd2: begin sda_pull = 1'b1; scl_pull = 1'b0;     end
          2'd3: begin sda_pull = 1'b1; scl_pull = 1'b1;     end
        endcase
      end
      ST_STOP: begin
        unique case (quarter)
          2'd0: begin sda_pull = 1'b1; scl_pull = 1'b1; end
          2'd1: begin sda_pull = 1'b1; scl_pull = 1'b0; end
          2'd2: begin sda_pull = 1'b1; scl_pull = 1'b0; end
          2'd3: begin sda_pull = 1'b0; scl_pull = 1'b0; end
        endcase
      end
      ST_BIT: begin
        sda_pull = ~bit_val;
        scl_pull = (quarter == 2'd0) || (quarter == 2'd3);
      end
      default: ;
    endcase

    // A slave holding SCL low freezes the quarter counter.
    stretch = ~scl_pull & ~uio_in[1];
    tick    = (cnt == div) & ~stretch;
    last_q  = tick & (quarter == 2'd3);

    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (req) begin
          unique case (op)
            OP_START, OP_RESTART:                 state_nx = ST_START;
            OP_STOP:                              state_nx = ST_STOP;
            OP_WRITE, OP_READ_ACK, OP_READ_NACK:  state_nx = ST_BIT;
            default:                              state_nx = ST_IDLE;
          endcase
        end
      end
      ST_START, ST_STOP: begin
        if (last_q) state_nx = ST_IDLE;
      end
      ST_BIT: begin
        if (last_q && (bit_idx == 4'd8)) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= ST_IDLE;
      strobe_q   <= 1'b0;
      div        <= DEFAULT_DIV;
      cnt        <= 8'd0;
      quarter    <= 2'd0;
      bit_idx    <= 4'd0;
      shreg      <= 8'd0;
      is_read    <= 1'b0;
      ack_low    <= 1'b0;
      sda_sample <= 1'b0;
      idle_sda   <= 1'b0;
      idle_scl   <= 1'b0;
      nack       <= 1'b0;
      rx_byte    <= 8'd0;
      busy       <= 1'b0;
    end else begin
      strobe_q <= uio_in[7];
      state    <= state_nx;
      busy     <= (state_nx != ST_IDLE);
      if (state == ST_IDLE) begin
        cnt     <= 8'd0;
        quarter <= 2'd0;
        bit_idx <= 4'd0;
        if (req) begin
          unique case (op)
            OP_SET_DIV: div <= ui_in;
            OP_WRITE: begin
              shreg   <= ui_in;
              is_read <= 1'b0;
              ack_low <= 1'b0;
            end
            OP_READ_ACK, OP_READ_NACK: begin
              shreg   <= 8'hFF;
              is_read <= 1'b1;
              ack_low <= (op == OP_READ_ACK);
            end
            default: ;
          endcase
        end
      end else begin
        if (tick) begin
          cnt     <= 8'd0;
          quarter <= quarter + 2'd1;
          if (quarter == 2'd2) sda_sample <= uio_in[0];
        end else if (!stretch) begin
          cnt <= cnt + 8'd1;
        end
        if (last_q) begin
          // Line levels at the end of a sequence persist until the next command.
          idle_sda <= sda_pull;
          idle_scl <= scl_pull;
          if (state == ST_BIT) begin
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx != 4'd8) shreg <= {shreg[6:0], sda_sample};
            if (is_read && (bit_idx == 4'd7)) rx_byte <= {shreg[6:0], sda_sample};
            if (!is_read && (bit_idx == 4'd8)) nack <= sda_sample;
          end
        end
      end
    end
  end

  assign uo_out  = rx_byte;
  assign uio_out = {4'b0000, nack, busy, 2'b00};
  // Reset releases both lines without waiting for a clock edge.
  assign uio_oe  = {4'b0000, 2'b11, scl_pull & ~rst_n, sda_pull & ~rst_n};

endmodule

// File: tb/tb_dlmiles_tqvph_i2c.sv
// Bench for dlmiles_tqvph_i2c: open-drain bus with a slave model and a bus
// monitor that decodes START/STOP/bits, checked against command-level expectations.
`timescale 1ns/1ps
module tb_dlmiles_tqvph_i2c;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena = 1'b1;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       strobe;
  logic [2:0] opcode;
  logic       slave_sda_low;
  logic       slave_scl_low;
  logic       sda_line;
  logic       scl_line;

  assign sda_line = ~uio_oe[0] & ~slave_sda_low;
  assign scl_line = ~uio_oe[1] & ~slave_scl_low;
  assign uio_in   = {strobe, opcode, 2'b00, scl_line, sda_line};

  dlmiles_tqvph_i2c #(.DEFAULT_DIV(8'd4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // ---------------- bus monitor + slave ----------------
  localparam logic [1:0] EV_START = 2'd2;
  localparam logic [1:0] EV_STOP  = 2'd3;

  logic [1:0] obs_q[$];
  logic [1:0] exp_q[$];
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       mon_bit  = 1'b1;
  logic       mon_cond = 1'b0;
  int         fall_cnt = 0;

  // A bit is reported on SCL fall unless START/STOP happened while SCL was high.
  always @(scl_line or sda_line) begin
    if (scl_line && !prev_scl) begin
      mon_bit  = sda_line;
      mon_cond = 1'b0;
    end else if (!scl_line && prev_scl) begin
      fall_cnt++;
      if (!mon_cond) obs_q.push_back({1'b0, mon_bit});
    end else if (scl_line && prev_scl && (sda_line != prev_sda)) begin
      obs_q.push_back(sda_line ? EV_STOP : EV_START);
      mon_cond = 1'b1;
    end
    prev_scl = scl_line;
    prev_sda = sda_line;
  end

  int         slave_mode = 0;  // 0 idle, 1 ACK a write, 2 send slave_byte
  logic [7:0] slave_byte = 8'h00;
  int         fall_base  = 0;
  int         slave_idx;
  assign slave_idx = fall_cnt - fall_base;

  always_comb begin
    slave_sda_low = 1'b0;
    if (slave_mode == 1 && slave_idx == 8) slave_sda_low = 1'b1;
    if (slave_mode == 2 && slave_idx >= 0 && slave_idx < 8)
      slave_sda_low = ~slave_byte[3'(7 - slave_idx)];
  end

  // ---------------- scoreboard / model state ----------------
  int         checks   = 0;
  int         failures = 0;
  int         div_m    = 4;
  logic       exp_nack = 1'b0;
  logic [7:0] exp_uo   = 8'h00;
  logic       exp_scl_pull = 1'b0;
  logic       exp_sda_pull = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_oe"}, uio_oe, {4'h0, 2'b11, exp_scl_pull, exp_sda_pull});
    check({tag, "_uio_out"}, uio_out, {4'h0, exp_nack, 1'b0, 2'b00});
    check({tag, "_uo_out"}, uo_out, exp_uo);
  endtask

  task automatic drain(input string tag);
    int n_obs, n_exp;
    n_obs = obs_q.size();
    n_exp = exp_q.size();
    check({tag, "_events"}, n_obs, n_exp);
    for (int i = 0; i < n_exp && i < n_obs; i++)
      check($sformatf("%s[%0d]", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic cmd(input logic [2:0] op, input logic [7:0] d, input int stretch_cyc,
                     input bit extra, output int len);
    int t0, n;
    @(negedge clk);
    opcode = op;
    ui_in  = d;
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    t0 = cyc;
    if (stretch_cyc > 0) begin
      n = 0;
      while (slave_idx < 2 && n < 2000) begin @(negedge clk); n++; end
      slave_scl_low = 1'b1;
      n = 0;
      while (uio_oe[1] && n < 2000) begin @(negedge clk); n++; end
      repeat (stretch_cyc) @(negedge clk);
      slave_scl_low = 1'b0;
    end
    if (extra) begin
      repeat (3) @(negedge clk);
      opcode = 3'd1;
      strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
    end
    n = 0;
    while (uio_out[2] && n < 5000) begin @(negedge clk); n++; end
    check("busy_timeout", (n < 5000), 1);
    len = cyc - t0;
  endtask

  task automatic m_set_div(input int v);
    int len;
    cmd(3'd6, 8'(v), 0, 1'b0, len);
    div_m = v;
    check("setdiv_no_busy", len, 0);
    drain("setdiv_bus");
  endtask

  task automatic m_start(input bit restart);
    int len;
    exp_q.push_back(EV_START);
    cmd(restart ? 3'd7 : 3'd1, 8'($urandom), 0, 1'b0, len);
    check("start_len", len, 4 * (div_m + 1));
    exp_scl_pull = 1'b1;
    exp_sda_pull = 1'b1;
    drain("start_bus");
    check_idle("start_idle");
  endtask

  task automatic m_stop();
    int len;
    exp_q.push_back(EV_STOP);
    cmd(3'd2, 8'($urandom), 0, 1'b0, len);
    check("stop_len", len, 4 * (div_m + 1));
    exp_scl_pull = 1'b0;
    exp_sda_pull = 1'b0;
    drain("stop_bus");
    check_idle("stop_idle");
  endtask

  task automatic m_write(input logic [7:0] b, input bit slave_ack, input int stretch_cyc,
                         input bit extra);
    int len;
    fall_base  = fall_cnt;
    slave_mode = slave_ack ? 1 : 0;
    for (int i = 7; i >= 0; i--) exp_q.push_back({1'b0, b[i]});
    exp_q.push_back({1'b0, ~slave_ack});
    cmd(3'd3, b, stretch_cyc, extra, len);
    slave_mode = 0;
    check("write_len", len, 36 * (div_m + 1) + stretch_cyc);
    exp_nack     = ~slave_ack;
    exp_scl_pull = 1'b1;
    exp_sda_pull = 1'b0;
    drain("write_bus");
    check_idle("write_idle");
  endtask

  task automatic m_read(input logic [7:0] b, input bit ack);
    int len;
    fall_base  = fall_cnt;
    slave_byte = b;
    slave_mode = 2;
    for (int i = 7; i >= 0; i--) exp_q.push_back({1'b0, b[i]});
    exp_q.push_back({1'b0, ~ack});
    cmd(ack ? 3'd4 : 3'd5, 8'($urandom), 0, 1'b0, len);
    slave_mode = 0;
    check("read_len", len, 36 * (div_m + 1));
    exp_uo       = b;
    exp_scl_pull = 1'b1;
    exp_sda_pull = ack;
    drain("read_bus");
    check_idle("read_idle");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int len, k;
    rst_n         = 1'b1;
    strobe        = 1'b0;
    opcode        = 3'd0;
    ui_in         = 8'h00;
    slave_scl_low = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_oe", uio_oe, 8'h0C);
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    m_set_div(0);
    m_set_div(1);
    m_start(1'b0);

    m_write(8'hA5, 1'b1, 0, 1'b0);
    m_write(8'hA5, 1'b0, 0, 1'b0);

    m_read(8'h3C, 1'b0);
    m_read(8'($urandom), 1'b1);

    m_write(8'($urandom), 1'b1, 20, 1'b0);
    m_write(8'($urandom), 1'b1, 0, 1'b1);
    m_stop();

    cmd(3'd0, 8'h00, 0, 1'b0, len);
    check("nop_no_busy", len, 0);
    drain("nop_bus");
    check_idle("nop_idle");

    for (int it = 0; it < 6; it++) begin
      m_set_div($urandom_range(0, 3));
      m_start(1'($urandom));
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(0, 1) == 0) m_write(8'($urandom), 1'($urandom), 0, 1'b0);
        else                           m_read(8'($urandom), 1'($urandom));
      end
      if ($urandom_range(0, 1) == 0) m_start(1'b1);
      m_stop();
    end

    // Reset in the middle of a write.
    m_start(1'b0);
    @(negedge clk);
    opcode = 3'd3;
    ui_in  = 8'h00;
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midop_reset_oe", uio_oe, 8'h0C);
    @(negedge clk);
    check("midop_reset_busy", uio_out, 8'h00);
    check("midop_reset_uo", uo_out, 8'h00);
    rst_n = 1'b0;
    @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    div_m        = 4;
    exp_nack     = 1'b0;
    exp_uo       = 8'h00;
    exp_scl_pull = 1'b0;
    exp_sda_pull = 1'b0;
    check_idle("after_midop_reset");
    m_start(1'b0);
    m_stop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
